// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART TX constants: state encodings, default baud divisor, frame length
// Frame length and the PARITY state follow the UART_TX_PARITY_EN build macro.
package uart_tx_fifo_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int DEFAULT_DELAY_FRAMES = 234;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - synchronous FIFO, head word presented on rd_data without a read
// Overflow/underflow requests are dropped; level counts stored entries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A full FIFO refuses writes even when a read frees a slot on the same edge.
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined)
// FIFO feeds a frame FSM that chains frames with no idle gap while data is queued.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BAUD_W = $clog2(DELAY_FRAMES);

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_last;
    logic              pop;
    logic              line_next;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready  = !fifo_full;
    assign busy      = (state != ST_IDLE) || (fifo_level != '0);
    assign baud_last = (baud_cnt == BAUD_W'(DELAY_FRAMES - 1));

    // Popping on the last stop cycle lets the next start bit follow immediately.
    assign pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));

    always_comb begin
        line_next = 1'b1;
        case (state)
            ST_START: line_next = 1'b0;
            ST_DATA:  line_next = shift[bit_cnt];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_next = even_parity(shift);
`endif
            default:  line_next = 1'b1;
        endcase
    end

    // uart_tx is one cycle behind the state, so each bit still lasts DELAY_FRAMES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx <= line_next;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_rd_data;
                        baud_cnt <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_rd_data;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench: line-decoding receiver plus byte scoreboard
// Honours UART_TX_PARITY_EN to expect 8E1 frames.
module tb_uart_tx_fifo;

    localparam int D     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * D;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_level;

    uart_tx_fifo #(
        .DELAY_FRAMES (D),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Receiver model: frame starts on a low line while idle; each bit must hold D cycles.
    logic [7:0]    exp_q[$];
    int            start_q[$];
    int            frames  = 0;
    int            mon_pos = -1;
    int            mon_b;
    logic [FB-1:0] mon_bits;
    logic          mon_stable;

    always @(negedge clk) begin
        if (rst) begin
            mon_pos = -1;
        end else if (mon_pos < 0) begin
            if (uart_tx == 1'b0) begin
                mon_bits    = '0;
                mon_stable  = 1'b1;
                mon_pos     = 1;
                start_q.push_back(cyc);
            end
        end else begin
            mon_b = mon_pos / D;
            if (mon_pos % D == 0) mon_bits[mon_b] = uart_tx;
            else if (uart_tx != mon_bits[mon_b]) mon_stable = 1'b0;
            mon_pos++;
            if (mon_pos == FLEN) begin
                mon_pos = -1;
                frames++;
                chk("frame_stable", mon_stable, 1'b1);
                chk("frame_stop", mon_bits[FB-1], 1'b1);
                if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
                else chk("frame_data", mon_bits[8:1], exp_q.pop_front());
`ifdef UART_TX_PARITY_EN
                chk("frame_parity", mon_bits[9], ^mon_bits[8:1]);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 500 && !in_ready; i++) tick();
        if (!in_ready) chk("push_ready_timeout", 0, 1);
        tick();
        acc = cyc;
        exp_q.push_back(d);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int n);
        for (int i = 0; i < 2000 && start_q.size() < n; i++) tick();
        if (start_q.size() < n) chk("start_timeout", start_q.size(), n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (busy || mon_pos >= 0 || exp_q.size() != 0); i++) tick();
        if (busy || mon_pos >= 0 || exp_q.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int a1, a, acc6, base, f0, s, waited;
    logic held_ok;
    logic [7:0] r;

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        repeat (3) tick();
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", in_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Single byte: latency and pattern
        base = start_q.size();
        push(8'hA5, a);
        tick();
        chk("t1_tx_n1", uart_tx, 1'b1);
        tick();
        chk("t1_tx_n2", uart_tx, 1'b0);
        chk("t1_busy_frame", busy, 1'b1);
        wait_idle();
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_frames", frames, 1);
        chk("t1_start", start_q[base], a + 2);

        // Back-to-back burst, then hold against a full FIFO
        base = start_q.size();
        f0   = frames;
        push(8'h01, a1);
        push(8'h02, a);
        push(8'h03, a);
        push(8'h04, a);
        chk("t2_b2b_acc", a, a1 + 3);
        chk("t2_level", fifo_level, 3);
        push(8'h05, a);
        chk("t3_acc5", a, a1 + 4);
        chk("t3_full_level", fifo_level, 4);
        chk("t3_full_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h06;
        held_ok  = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            if (fifo_level != 3'd4) held_ok = 1'b0;
            tick();
            waited++;
        end
        chk("t3_hold_level", held_ok, 1'b1);
        tick();
        acc6 = cyc;
        exp_q.push_back(8'h06);
        in_valid = 1'b0;
        chk("t3_acc6", acc6, a1 + 2 + FLEN);
        wait_idle();
        chk("t2_frames", frames - f0, 6);
        chk("t2_first_start", start_q[base], a1 + 2);
        for (int i = 1; i < 6; i++) chk("t2_gap", start_q[base + i] - start_q[base + i - 1], FLEN);

        // Reset mid-DATA with bytes still queued
        base = start_q.size();
        push(8'hFF, a);
        push(8'h11, a);
        push(8'h22, a);
        wait_start(base + 1);
        repeat (3 * D) tick();
        rst = 1'b1;
        #1;
        chk("t4_tx", uart_tx, 1'b1);
        chk("t4_level", fifo_level, 0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_ready", in_ready, 1'b1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        f0 = frames;
        push(8'h3C, a);
        wait_idle();
        chk("t4_frames", frames - f0, 1);
        chk("t4_lat", start_q[start_q.size() - 1], a + 2);

        // Push landing on the last STOP cycle of the final frame
        base = start_q.size();
        r = 8'($urandom);
        push(r, a);
        wait_start(base + 1);
        s = start_q[base];
        while (cyc < s + FLEN - 2) tick();
        r = 8'($urandom);
        push(r, a);
        chk("t6_acc", a, s + FLEN - 1);
        wait_start(base + 2);
        chk("t6_lat", start_q[base + 1], a + 2);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        base = start_q.size();
        push(8'h07, a);
        push(8'h03, a);
        wait_idle();
        chk("t5_len", start_q[base + 1] - start_q[base], 44);
`endif

        // Random bytes with random gaps
        f0 = frames;
        for (int i = 0; i < 12; i++) begin
            r = 8'($urandom);
            push(r, a);
            repeat ($urandom_range(0, 50)) tick();
        end
        wait_idle();
        chk("rand_frames", frames - f0, 12);
        chk("rand_level", fifo_level, 0);
        chk("rand_tx_idle", uart_tx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
